// File: rtl/add_pg_pipe.sv
// Pipelined WIDTH-bit add/subtract with group propagate/generate.
// One BLK_W-bit block is resolved per stage; the block carry is registered between stages.
module add_pg_pipe #(
    parameter int WIDTH = 32,
    parameter int BLK_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] val_out,
    output logic             carry_out,
    output logic             prop_out,
    output logic             gen_out,
    output logic             overflow
);

    localparam int NUM_BLK = WIDTH / BLK_W;

    if ((WIDTH % BLK_W) != 0) begin : g_bad_width
        $error("add_pg_pipe: WIDTH must be a multiple of BLK_W");
    end

    // Layer 0 holds the accepted operands; layer k+1 holds the result of stage k.
    // Layer NUM_BLK is the output register set.
    logic             r_vld [NUM_BLK+1];
    logic [WIDTH-1:0] r_a   [NUM_BLK];
    logic [WIDTH-1:0] r_b   [NUM_BLK];
    logic [WIDTH-1:0] r_sum [NUM_BLK+1];
    logic             r_c   [NUM_BLK+1];
    logic             r_p   [NUM_BLK+1];
    logic             r_g   [NUM_BLK+1];
    logic             r_ovf;

    logic [BLK_W:0]   w_add  [NUM_BLK];
    logic [BLK_W:0]   w_gen  [NUM_BLK];
    logic             w_p    [NUM_BLK];
    logic [WIDTH-1:0] w_nsum [NUM_BLK];
    logic             w_cmsb;
    logic             w_adv;

    assign w_adv     = !r_vld[NUM_BLK] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[NUM_BLK];
    assign val_out   = r_sum[NUM_BLK];
    assign carry_out = r_c[NUM_BLK];
    assign prop_out  = r_p[NUM_BLK];
    assign gen_out   = r_g[NUM_BLK];
    assign overflow  = r_ovf;

    always_comb begin
        for (int k = 0; k < NUM_BLK; k++) begin
            w_add[k] = {1'b0, r_a[k][k*BLK_W +: BLK_W]}
                     + {1'b0, r_b[k][k*BLK_W +: BLK_W]}
                     + {{BLK_W{1'b0}}, r_c[k]};
            // block generate is the carry-out with a zero carry-in
            w_gen[k] = {1'b0, r_a[k][k*BLK_W +: BLK_W]}
                     + {1'b0, r_b[k][k*BLK_W +: BLK_W]};
            w_p[k]   = &(r_a[k][k*BLK_W +: BLK_W] ^ r_b[k][k*BLK_W +: BLK_W]);
            w_nsum[k] = r_sum[k];
            w_nsum[k][k*BLK_W +: BLK_W] = w_add[k][BLK_W-1:0];
        end
        w_cmsb = w_add[NUM_BLK-1][BLK_W-1]
               ^ r_a[NUM_BLK-1][WIDTH-1]
               ^ r_b[NUM_BLK-1][WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= NUM_BLK; s++) begin
                r_vld[s] <= 1'b0;
                r_sum[s] <= '0;
                r_c[s]   <= 1'b0;
                r_p[s]   <= 1'b0;
                r_g[s]   <= 1'b0;
            end
            for (int s = 0; s < NUM_BLK; s++) begin
                r_a[s] <= '0;
                r_b[s] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            r_a[0]   <= val1;
            r_b[0]   <= sub ? ~val2 : val2;
            r_c[0]   <= sub | carry_in;
            r_sum[0] <= '0;
            r_p[0]   <= 1'b1;
            r_g[0]   <= 1'b0;
            for (int k = 0; k < NUM_BLK; k++) begin
                r_vld[k+1] <= r_vld[k];
                r_sum[k+1] <= w_nsum[k];
                r_c[k+1]   <= w_add[k][BLK_W];
                r_p[k+1]   <= r_p[k] & w_p[k];
                r_g[k+1]   <= w_gen[k][BLK_W] | (w_p[k] & r_g[k]);
            end
            for (int k = 1; k < NUM_BLK; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
            end
            r_ovf <= w_cmsb ^ w_add[NUM_BLK-1][BLK_W];
        end
    end

endmodule

// File: tb/tb_add_pg_pipe.sv
// Self-checking bench for add_pg_pipe (WIDTH=32, BLK_W=16): directed cases plus
// randomized streaming against an arithmetic reference model and result queue.
module tb_add_pg_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] val1;
    logic [31:0] val2;
    logic        carry_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] val_out;
    logic        carry_out;
    logic        prop_out;
    logic        gen_out;
    logic        overflow;

    add_pg_pipe #(.WIDTH(32), .BLK_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .val1(val1), .val2(val2), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .val_out(val_out), .carry_out(carry_out), .prop_out(prop_out),
        .gen_out(gen_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        p;
        logic        g;
        logic        v;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic s);
        logic [31:0] bb;
        logic [32:0] full;
        logic [32:0] nocin;
        exp_t        e;
        bb    = s ? ~b : b;
        full  = {1'b0, a} + {1'b0, bb} + (s ? 33'd1 : {32'd0, cin});
        nocin = {1'b0, a} + {1'b0, bb};
        e.sum = full[31:0];
        e.c   = full[32];
        e.p   = ((a ^ bb) == 32'hFFFF_FFFF);
        e.g   = nocin[32];
        e.v   = (a[31] == bb[31]) && (full[31] != a[31]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic s);
        in_valid = v;
        val1     = a;
        val2     = b;
        carry_in = cin;
        sub      = s;
    endtask

    // Advances one clock; scores any result consumed and queues any beat accepted at that edge.
    task automatic tick(output bit acc);
        bit   emit;
        exp_t e;
        #1;
        acc  = in_valid && in_ready && !rst;
        emit = out_valid && out_ready && !rst;
        if (emit) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("sb_val",  64'(val_out),   64'(e.sum));
                chk("sb_cout", 64'(carry_out), 64'(e.c));
                chk("sb_prop", 64'(prop_out),  64'(e.p));
                chk("sb_gen",  64'(gen_out),   64'(e.g));
                chk("sb_ovf",  64'(overflow),  64'(e.v));
                n_out++;
            end
        end
        if (acc) q.push_back(model(val1, val2, carry_in, sub));
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        bit a;
        tick(a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          idx;
        int          base;
        logic [31:0] ra [6];
        logic [31:0] rb [6];
        logic        rc [6];
        logic        rs [6];

        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_val_out",   64'(val_out),   64'd0);
        chk("rst_carry",     64'(carry_out), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // all-ones + 1: wrap with carry, latency exactly 2
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("lat_t0", 64'(out_valid), 64'd0);
        step();
        chk("lat_t1", 64'(out_valid), 64'd0);
        step();
        chk("lat_t2", 64'(out_valid), 64'd1);
        chk("wrap_val",  64'(val_out),   64'h0);
        chk("wrap_cout", 64'(carry_out), 64'd1);
        chk("wrap_prop", 64'(prop_out),  64'd0);
        chk("wrap_gen",  64'(gen_out),   64'd1);
        chk("wrap_ovf",  64'(overflow),  64'd0);

        // carry across the block boundary
        drive(1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        step();
        chk("bnd_valid", 64'(out_valid), 64'd1);
        chk("bnd_val",   64'(val_out),   64'h0001_0000);
        chk("bnd_cout",  64'(carry_out), 64'd0);
        chk("bnd_prop",  64'(prop_out),  64'd0);
        chk("bnd_gen",   64'(gen_out),   64'd0);

        // full propagate chain, back to back
        drive(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("prop0_valid", 64'(out_valid), 64'd1);
        chk("prop0_val",   64'(val_out),   64'hFFFF_FFFF);
        chk("prop0_cout",  64'(carry_out), 64'd0);
        chk("prop0_pg",    64'({prop_out, gen_out}), 64'b10);
        step();
        chk("prop1_valid", 64'(out_valid), 64'd1);
        chk("prop1_val",   64'(val_out),   64'h0);
        chk("prop1_cout",  64'(carry_out), 64'd1);
        chk("prop1_pg",    64'({prop_out, gen_out}), 64'b10);
        step();

        // subtract, carry_in ignored
        drive(1'b1, 32'd5, 32'd7, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'h8000_0000, 32'd1, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("sub0_val",  64'(val_out),   64'hFFFF_FFFE);
        chk("sub0_cout", 64'(carry_out), 64'd0);
        chk("sub0_ovf",  64'(overflow),  64'd0);
        step();
        chk("sub1_val",  64'(val_out),   64'h7FFF_FFFF);
        chk("sub1_cout", 64'(carry_out), 64'd1);
        chk("sub1_ovf",  64'(overflow),  64'd1);
        step();

        // backpressure: 6 random beats, out_ready low for 3 cycles mid-stream
        for (int i = 0; i < 6; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
            rc[i] = 1'($urandom_range(0, 1));
            rs[i] = 1'($urandom_range(0, 1));
        end
        idx  = 0;
        base = n_out;
        for (int c = 0; c < 60 && (idx < 6 || q.size() > 0); c++) begin
            out_ready = !(c >= 3 && c <= 5);
            if (idx < 6) drive(1'b1, ra[idx], rb[idx], rc[idx], rs[idx]);
            else         drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            if (c >= 3 && c <= 5) begin
                #1;
                chk("stall_in_ready",  64'(in_ready),  64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                if (q.size() > 0) chk("stall_hold", 64'(val_out), 64'(q[0].sum));
                else              chk("stall_queue", 64'd0, 64'd1);
            end
            tick(acc);
            if (acc) idx++;
        end
        out_ready = 1'b1;
        chk("bp_count", 64'(n_out - base), 64'd6);
        chk("bp_queue", 64'(q.size()), 64'd0);

        // random valid/ready traffic
        for (int c = 0; c < 40; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int c = 0; c < 10 && q.size() > 0; c++) step();
        chk("rand_drain", 64'(q.size()), 64'd0);

        // reset with two beats in flight
        drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_outputs", 64'({val_out, carry_out, prop_out, gen_out, overflow}), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("mrst_flush", 64'(out_valid), 64'd0);
        drive(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("post_t0", 64'(out_valid), 64'd0);
        step();
        chk("post_t1", 64'(out_valid), 64'd0);
        step();
        chk("post_t2", 64'(out_valid), 64'd1);
        chk("post_val", 64'(val_out), 64'h0000_0031);
        step();
        chk("final_queue", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
